msrv32_dmem_ctrl: RTL and testbench

Data-memory access controller for the msrv32 core. It accepts one load or store request at a time from the execute stage and sequences it as a single AHB-Lite transfer (address phase, then data phase with wait states). It also generates the byte-lane write mask and replicated store data, and returns load data already lane-selected and sign- or zero-extended, matching the load-unit semantics. It stalls the pipeline for the whole transfer and reports bus errors.

---
 rtl/msrv32_dmem_ctrl_if.sv | 34 +++
 rtl/msrv32_dmem_ctrl.sv | 170 +++++++++++++++++
 tb/tb_msrv32_dmem_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msrv32_dmem_ctrl_if.sv
// AHB-Lite data-side bus bundle for the msrv32 data-memory controller.
// The controller is the master; the memory or interconnect is the slave.
interface msrv32_dmem_ctrl_if;
    logic [31:0] ms_riscv32_mp_dmaddr_out;
    logic [1:0]  ms_riscv32_mp_data_htrans_out;
    logic        ms_riscv32_mp_dmwr_req_out;
    logic [3:0]  ms_riscv32_mp_dmwr_mask_out;
    logic [31:0] ms_riscv32_mp_dmdata_out;
    logic [31:0] ms_riscv32_mp_dmdata_in;
    logic        ms_riscv32_mp_hready_in;
    logic        ms_riscv32_mp_hresp_in;

    modport master (
        output ms_riscv32_mp_dmaddr_out,
        output ms_riscv32_mp_data_htrans_out,
        output ms_riscv32_mp_dmwr_req_out,
        output ms_riscv32_mp_dmwr_mask_out,
        output ms_riscv32_mp_dmdata_out,
        input  ms_riscv32_mp_dmdata_in,
        input  ms_riscv32_mp_hready_in,
        input  ms_riscv32_mp_hresp_in
    );

    modport slave (
        input  ms_riscv32_mp_dmaddr_out,
        input  ms_riscv32_mp_data_htrans_out,
        input  ms_riscv32_mp_dmwr_req_out,
        input  ms_riscv32_mp_dmwr_mask_out,
        input  ms_riscv32_mp_dmdata_out,
        output ms_riscv32_mp_dmdata_in,
        output ms_riscv32_mp_hready_in,
        output ms_riscv32_mp_hresp_in
    );
endinterface

// File: rtl/msrv32_dmem_ctrl.sv
// msrv32 data-memory controller: one AHB-Lite transfer per load/store, lane masking and load extension.
// Optional MSRV32_MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and pulse misaligned_out.
module msrv32_dmem_ctrl (
    input  logic                      ms_riscv32_mp_clk_in,
    input  logic                      ms_riscv32_mp_rst_in,
    input  logic                      mem_req_in,
    input  logic                      mem_we_in,
    input  logic [1:0]                load_size_in,
    input  logic                      load_unsigned_in,
    input  logic [31:0]               iadder_in,
    input  logic [31:0]               rs2_in,
    msrv32_dmem_ctrl_if.master        bus,
    output logic                      stall_out,
    output logic [31:0]               load_data_out,
    output logic                      load_valid_out,
    output logic                      bus_err_out,
    output logic                      misaligned_out
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] ldata_q, ldata_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        mis_q, mis_d;

    logic        accept;
    logic        misaligned;
    logic [3:0]  req_mask;
    logic [31:0] req_wdata;

    function automatic logic [31:0] load_extract(input logic [31:0] d, input logic [1:0] sz,
                                                 input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(d >> {off, 3'b000});
        h = off[1] ? d[31:16] : d[15:0];
        case (sz)
            2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: return d;
        endcase
    endfunction

`ifdef MSRV32_MISALIGN_TRAP_EN
    assign misaligned = ((load_size_in == 2'b01) && iadder_in[0]) ||
                        (load_size_in[1] && (iadder_in[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        req_mask  = 4'hF;
        req_wdata = rs2_in;
        case (load_size_in)
            2'b00: begin
                req_mask  = 4'b0001 << iadder_in[1:0];
                req_wdata = {4{rs2_in[7:0]}};
            end
            2'b01: begin
                req_mask  = 4'b0011 << {iadder_in[1], 1'b0};
                req_wdata = {2{rs2_in[15:0]}};
            end
            default: ;
        endcase
        if (!mem_we_in) req_mask = 4'b0000;
    end

    assign accept = ((state_q == IDLE) || (state_q == RESP)) && mem_req_in;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        ldata_d = ldata_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        mis_d   = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    we_d    = mem_we_in;
                    size_d  = load_size_in;
                    uns_d   = load_unsigned_in;
                    off_d   = iadder_in[1:0];
                    addr_d  = {iadder_in[31:2], 2'b00};
                    wdata_d = req_wdata;
                    mask_d  = req_mask;
                    if (misaligned) begin
                        state_d = RESP;
                        mis_d   = 1'b1;
                        ldata_d = 32'b0;
                    end else begin
                        state_d = ADDR;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: if (bus.ms_riscv32_mp_hready_in) state_d = DATA;
            DATA: begin
                if (bus.ms_riscv32_mp_hready_in) begin
                    state_d = RESP;
                    if (bus.ms_riscv32_mp_hresp_in) begin
                        err_d   = 1'b1;
                        ldata_d = 32'b0;
                    end else if (!we_q) begin
                        valid_d = 1'b1;
                        ldata_d = load_extract(bus.ms_riscv32_mp_dmdata_in, size_q, off_q, uns_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            addr_q  <= 32'b0;
            wdata_q <= 32'b0;
            mask_q  <= 4'b0000;
            ldata_q <= 32'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            ldata_q <= ldata_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
        end
    end

    assign bus.ms_riscv32_mp_dmaddr_out      = addr_q;
    assign bus.ms_riscv32_mp_data_htrans_out = (state_q == ADDR) ? 2'b10 : 2'b00;
    assign bus.ms_riscv32_mp_dmwr_req_out    = (state_q == ADDR) && we_q;
    assign bus.ms_riscv32_mp_dmwr_mask_out   = mask_q;
    assign bus.ms_riscv32_mp_dmdata_out      = wdata_q;

    assign stall_out      = (state_q == ADDR) || (state_q == DATA) || accept;
    assign load_data_out  = ldata_q;
    assign load_valid_out = valid_q;
    assign bus_err_out    = err_q;
    assign misaligned_out = mis_q;
endmodule

// File: tb/tb_msrv32_dmem_ctrl.sv
// Directed bench for msrv32_dmem_ctrl: a per-transaction timeline model checked every cycle,
// plus literal checks of reset values and key results. Honours MSRV32_MISALIGN_TRAP_EN.
module tb_msrv32_dmem_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mem_req, mem_we, uns;
    logic [1:0]  sz;
    logic [31:0] iadder, rs2;
    logic        stall, load_valid, bus_err, mis_o;
    logic [31:0] ldata;

    msrv32_dmem_ctrl_if bus();

    msrv32_dmem_ctrl dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .mem_req_in           (mem_req),
        .mem_we_in            (mem_we),
        .load_size_in         (sz),
        .load_unsigned_in     (uns),
        .iadder_in            (iadder),
        .rs2_in               (rs2),
        .bus                  (bus),
        .stall_out            (stall),
        .load_data_out        (ldata),
        .load_valid_out       (load_valid),
        .bus_err_out          (bus_err),
        .misaligned_out       (mis_o)
    );

    int total, bad;

    // Expected outputs for the current cycle, written just after each rising edge.
    logic [1:0]  e_htrans;
    logic        e_stall, e_valid, e_err, e_mis, e_bus, e_wdchk, e_wr;
    logic [31:0] e_ldata, e_addr, e_wdata;
    logic [3:0]  e_mask;
    logic        pend_valid, pend_err, pend_mis;
    logic [31:0] pend_ldata;
    bit          chk_en;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mdl_load(input logic [31:0] d, input logic [1:0] s,
                                             input logic u, input logic [1:0] o);
        int b[4];
        int v;
        int base;
        for (int k = 0; k < 4; k++) b[k] = int'(d[8*k +: 8]);
        if (s == 2'b00) begin
            v = b[int'(o)];
            if (!u && v >= 128) v -= 256;
        end else if (s == 2'b01) begin
            base = o[1] ? 2 : 0;
            v = b[base] + 256 * b[base + 1];
            if (!u && v >= 32768) v -= 65536;
        end else begin
            return d;
        end
        return 32'(v);
    endfunction

    function automatic logic [3:0] mdl_mask(input logic [1:0] s, input logic [1:0] o);
        if (s == 2'b00) return 4'(1 << o);
        if (s == 2'b01) return o[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] mdl_wdata(input logic [1:0] s, input logic [31:0] r);
        if (s == 2'b00) return {4{r[7:0]}};
        if (s == 2'b01) return {2{r[15:0]}};
        return r;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("htrans", 32'(bus.ms_riscv32_mp_data_htrans_out), 32'(e_htrans));
            chk("stall", 32'(stall), 32'(e_stall));
            chk("load_valid", 32'(load_valid), 32'(e_valid));
            chk("bus_err", 32'(bus_err), 32'(e_err));
            chk("misaligned", 32'(mis_o), 32'(e_mis));
            if (e_valid || e_err || e_mis) chk("load_data", ldata, e_ldata);
            if (e_bus) begin
                chk("dmaddr", bus.ms_riscv32_mp_dmaddr_out, e_addr);
                chk("wr_req", 32'(bus.ms_riscv32_mp_dmwr_req_out), 32'(e_wr));
                chk("wr_mask", 32'(bus.ms_riscv32_mp_dmwr_mask_out), 32'(e_mask));
            end
            if (e_wdchk) chk("dmdata_out", bus.ms_riscv32_mp_dmdata_out, e_wdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_defaults();
        e_htrans = 2'b00;
        e_stall  = 1'b0;
        e_valid  = pend_valid;
        e_err    = pend_err;
        e_mis    = pend_mis;
        e_ldata  = pend_ldata;
        e_bus    = 1'b0;
        e_wdchk  = 1'b0;
        pend_valid = 1'b0;
        pend_err   = 1'b0;
        pend_mis   = 1'b0;
        pend_ldata = 32'b0;
        mem_req = 1'b0;
        bus.ms_riscv32_mp_hready_in = 1'b1;
        bus.ms_riscv32_mp_hresp_in  = 1'b0;
    endtask

    task automatic idle();
        cyc_defaults();
        step();
    endtask

    task automatic present(input logic we, input logic [1:0] s, input logic u,
                           input logic [31:0] a, input logic [31:0] r);
        cyc_defaults();
        mem_req = 1'b1;
        mem_we  = we;
        sz      = s;
        uns     = u;
        iadder  = a;
        rs2     = r;
        e_stall = 1'b1;
        e_addr  = {a[31:2], 2'b00};
        e_wr    = we;
        e_mask  = we ? mdl_mask(s, a[1:0]) : 4'b0000;
        e_wdata = mdl_wdata(s, r);
    endtask

    task automatic run_txn(input logic we, input logic [1:0] s, input logic u,
                           input logic [31:0] a, input logic [31:0] r, input logic [31:0] rd,
                           input int wa, input int wd, input logic er);
        logic mis;
        mis = 1'b0;
`ifdef MSRV32_MISALIGN_TRAP_EN
        mis = ((s == 2'b01) && a[0]) || (s[1] && (a[1:0] != 2'b00));
`endif
        present(we, s, u, a, r);
        step();
        if (mis) begin
            pend_mis   = 1'b1;
            pend_ldata = 32'b0;
        end else begin
            for (int i = 0; i <= wa; i++) begin
                cyc_defaults();
                mem_req  = 1'b1;
                e_htrans = 2'b10;
                e_stall  = 1'b1;
                e_bus    = 1'b1;
                e_wdchk  = we;
                bus.ms_riscv32_mp_hready_in = (i == wa);
                step();
            end
            for (int i = 0; i <= wd; i++) begin
                cyc_defaults();
                mem_req = 1'b1;
                e_stall = 1'b1;
                e_wdchk = we;
                bus.ms_riscv32_mp_hready_in = (i == wd);
                bus.ms_riscv32_mp_hresp_in  = er && (i == wd);
                bus.ms_riscv32_mp_dmdata_in = rd;
                step();
            end
            if (er) begin
                pend_err   = 1'b1;
                pend_ldata = 32'b0;
            end else if (!we) begin
                pend_valid = 1'b1;
                pend_ldata = mdl_load(rd, s, u, a[1:0]);
            end
        end
    endtask

    task automatic resp_lit(input string nm, input logic v, input logic er, input logic mi,
                            input logic [31:0] ld);
        cyc_defaults();
        @(negedge clk);
        #1;
        chk({nm, "_valid"}, 32'(load_valid), 32'(v));
        chk({nm, "_err"}, 32'(bus_err), 32'(er));
        chk({nm, "_mis"}, 32'(mis_o), 32'(mi));
        chk({nm, "_data"}, ldata, ld);
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        chk_en = 1'b0;
        pend_valid = 1'b0;
        pend_err = 1'b0;
        pend_mis = 1'b0;
        pend_ldata = 32'b0;
        e_addr = 32'b0;
        e_wdata = 32'b0;
        e_mask = 4'b0;
        e_wr = 1'b0;
        rst = 1'b1;
        mem_we = 1'b0;
        sz = 2'b00;
        uns = 1'b0;
        iadder = 32'b0;
        rs2 = 32'b0;
        bus.ms_riscv32_mp_dmdata_in = 32'b0;
        cyc_defaults();

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_htrans", 32'(bus.ms_riscv32_mp_data_htrans_out), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_dmaddr", bus.ms_riscv32_mp_dmaddr_out, 32'd0);
        chk("rst_dmdata", bus.ms_riscv32_mp_dmdata_out, 32'd0);
        chk("rst_ldata", ldata, 32'd0);
        chk("rst_mask", 32'(bus.ms_riscv32_mp_dmwr_mask_out), 32'd0);
        chk("rst_wr", 32'(bus.ms_riscv32_mp_dmwr_req_out), 32'd0);
        chk("rst_pulses", {29'b0, load_valid, bus_err, mis_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        idle();

        // Signed byte load, lane 1 of A5B6C7D8, zero wait.
        run_txn(1'b0, 2'b00, 1'b0, 32'h1000_0001, 32'h0, 32'hA5B6C7D8, 0, 0, 1'b0);
        resp_lit("lb", 1'b1, 1'b0, 1'b0, 32'hFFFFFFC7);

        // Unsigned upper-half load with two data-phase waits.
        run_txn(1'b0, 2'b01, 1'b1, 32'h1000_0002, 32'h0, 32'hA5B6C7D8, 0, 2, 1'b0);
        resp_lit("lhu", 1'b1, 1'b0, 1'b0, 32'h0000A5B6);

        // Byte store with one address-phase wait: no pulse expected.
        run_txn(1'b1, 2'b00, 1'b0, 32'h1000_0001, 32'h123456EF, 32'h0, 1, 0, 1'b0);
        idle();

        // Word load terminated with an error response.
        run_txn(1'b0, 2'b10, 1'b0, 32'h1000_0008, 32'h0, 32'h01234567, 0, 1, 1'b1);
        resp_lit("lw_err", 1'b0, 1'b1, 1'b0, 32'h0);

        // Back-to-back accesses, each new request presented in the previous RESP cycle.
        run_txn(1'b0, 2'b01, 1'b0, 32'h1000_0010, 32'h0, 32'h00008001, 0, 0, 1'b0);
        run_txn(1'b1, 2'b01, 1'b0, 32'h1000_0012, 32'h0000BEEF, 32'h0, 0, 0, 1'b0);
        run_txn(1'b1, 2'b10, 1'b0, 32'h1000_0014, 32'hCAFEBABE, 32'h0, 1, 1, 1'b0);
        run_txn(1'b0, 2'b00, 1'b1, 32'h1000_0013, 32'h0, 32'h80000000, 0, 0, 1'b0);
        resp_lit("lbu", 1'b1, 1'b0, 1'b0, 32'h00000080);
        run_txn(1'b0, 2'b11, 1'b0, 32'h1000_0018, 32'h0, 32'hF00DFACE, 0, 0, 1'b0);
        idle();

        // Reset asserted while the data phase is waiting.
        present(1'b0, 2'b10, 1'b0, 32'h1000_0020, 32'h0);
        step();
        cyc_defaults();
        mem_req = 1'b1;
        e_htrans = 2'b10;
        e_stall = 1'b1;
        e_bus = 1'b1;
        step();
        cyc_defaults();
        mem_req = 1'b1;
        e_stall = 1'b1;
        bus.ms_riscv32_mp_hready_in = 1'b0;
        step();
        cyc_defaults();
        bus.ms_riscv32_mp_hready_in = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstmid_htrans", 32'(bus.ms_riscv32_mp_data_htrans_out), 32'd0);
        chk("rstmid_stall", 32'(stall), 32'd0);
        step();
        rst = 1'b0;
        repeat (3) idle();

        // Word load at an odd address.
        run_txn(1'b0, 2'b10, 1'b0, 32'h1000_0031, 32'h0, 32'h11223344, 0, 0, 1'b0);
`ifdef MSRV32_MISALIGN_TRAP_EN
        resp_lit("lw_mis", 1'b0, 1'b0, 1'b1, 32'h0);
`else
        resp_lit("lw_mis", 1'b1, 1'b0, 1'b0, 32'h11223344);
`endif
        repeat (2) idle();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
